// File: rtl/video_palsched.sv
// Palette RAM write scheduler: arbitrates ATM/ULAplus palette writes into a small FIFO,
// drains one entry per clock (optionally only in blanking) and sequences the default ZX palette.
module video_palsched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hblank,
    input  logic        vblank,
    input  logic        defer_ena,
    input  logic        atm_req,
    input  logic [3:0]  atm_addr,
    input  logic [11:0] atm_data,
    output logic        atm_ack,
    input  logic        up_req,
    input  logic [5:0]  up_addr,
    input  logic [7:0]  up_data,
    output logic        up_ack,
    input  logic        init_start,
    output logic        pal_we,
    output logic [7:0]  pal_addr,
    output logic [11:0] pal_wdata,
    output logic        busy,
    output logic [4:0]  fifo_cnt
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_INIT  = 2'd3;

    // Default ZX colour: each set colour bit takes level A (normal) or F (bright, i[3]).
    function automatic logic [11:0] def_color(input logic [3:0] i);
        logic [3:0] lvl;
        lvl = i[3] ? 4'hF : 4'hA;
        return {i[1] ? lvl : 4'h0, i[2] ? lvl : 4'h0, i[0] ? lvl : 4'h0};
    endfunction

    logic [1:0]    state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]    init_cnt_q, init_cnt_d;
    logic          atm_ack_q, atm_ack_d, up_ack_q, up_ack_d;
    logic          pal_we_q, pal_we_d, busy_q, busy_d;
    logic [7:0]    pal_addr_q, pal_addr_d;
    logic [11:0]   pal_wdata_q, pal_wdata_d;
    logic [19:0]   mem_q [FIFO_DEPTH];

    logic        in_init, drain_ok, push_ok, atm_take, up_take, push, pop;
    logic [11:0] up_fmt;
    logic [19:0] push_entry;

    always_comb begin
        in_init  = (state_q == S_INIT);
        drain_ok = !defer_ena | hblank | vblank;
        // Push decision uses pre-edge occupancy, so a full FIFO blocks even with a same-edge pop.
        push_ok  = !in_init && !init_start && (cnt_q < DEPTH_C);
        atm_take = push_ok && atm_req && !atm_ack_q;
        up_take  = push_ok && !atm_take && up_req && !up_ack_q;
        push     = atm_take | up_take;
        pop      = !in_init && !init_start && (cnt_q != 5'd0) && drain_ok;
        up_fmt   = {up_data[7:5], up_data[7], up_data[4:2], up_data[4],
                    up_data[1:0], |up_data[1:0], up_data[1]};
        push_entry = atm_take ? {4'd0, atm_addr, atm_data} : {2'b10, up_addr, up_fmt};

        state_d     = state_q;
        cnt_d       = cnt_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        init_cnt_d  = init_cnt_q;
        atm_ack_d   = atm_take;
        up_ack_d    = up_take;
        pal_we_d    = 1'b0;
        pal_addr_d  = pal_addr_q;
        pal_wdata_d = pal_wdata_q;

        if (init_start) begin
            state_d     = S_INIT;
            cnt_d       = 5'd0;
            wptr_d      = '0;
            rptr_d      = '0;
            init_cnt_d  = 4'd0;
            pal_we_d    = 1'b1;
            pal_addr_d  = 8'h00;
            pal_wdata_d = def_color(4'd0);
        end else if (in_init) begin
            if (init_cnt_q == 4'hF) begin
                state_d = S_IDLE;
            end else begin
                init_cnt_d  = init_cnt_q + 4'd1;
                pal_we_d    = 1'b1;
                pal_addr_d  = {4'd0, init_cnt_d};
                pal_wdata_d = def_color(init_cnt_d);
            end
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop) begin
                rptr_d                    = rptr_q + PW'(1);
                pal_we_d                  = 1'b1;
                {pal_addr_d, pal_wdata_d} = mem_q[rptr_q];
            end
            cnt_d = cnt_q + {4'd0, push} - {4'd0, pop};
            if (cnt_d == 5'd0)  state_d = S_IDLE;
            else if (drain_ok)  state_d = S_DRAIN;
            else                state_d = S_HOLD;
        end
        busy_d = (state_d == S_INIT) | (cnt_d != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            init_cnt_q  <= 4'd0;
            atm_ack_q   <= 1'b0;
            up_ack_q    <= 1'b0;
            pal_we_q    <= 1'b0;
            pal_addr_q  <= 8'h00;
            pal_wdata_q <= 12'h000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            init_cnt_q  <= init_cnt_d;
            atm_ack_q   <= atm_ack_d;
            up_ack_q    <= up_ack_d;
            pal_we_q    <= pal_we_d;
            pal_addr_q  <= pal_addr_d;
            pal_wdata_q <= pal_wdata_d;
            busy_q      <= busy_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_entry;
    end

    assign atm_ack   = atm_ack_q;
    assign up_ack    = up_ack_q;
    assign pal_we    = pal_we_q;
    assign pal_addr  = pal_addr_q;
    assign pal_wdata = pal_wdata_q;
    assign busy      = busy_q;
    assign fifo_cnt  = cnt_q;
endmodule

// File: tb/tb_video_palsched.sv
// Directed bench for video_palsched: a queue-based scoreboard checks every cycle,
// literal expectations pin the formatting, ordering, latency and init sequence.
module tb_video_palsched;
    localparam int DEPTH = 4;

    logic        clk = 0, rst_n = 0, hblank = 0, vblank = 0, defer_ena = 0;
    logic        atm_req = 0, up_req = 0, init_start = 0;
    logic [3:0]  atm_addr = 0;
    logic [11:0] atm_data = 0;
    logic [5:0]  up_addr = 0;
    logic [7:0]  up_data = 0;
    logic        atm_ack, up_ack, pal_we, busy;
    logic [7:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic [4:0]  fifo_cnt;

    int checks = 0, failures = 0;

    video_palsched #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .hblank(hblank), .vblank(vblank), .defer_ena(defer_ena),
        .atm_req(atm_req), .atm_addr(atm_addr), .atm_data(atm_data), .atm_ack(atm_ack),
        .up_req(up_req), .up_addr(up_addr), .up_data(up_data), .up_ack(up_ack),
        .init_start(init_start), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .busy(busy), .fifo_cnt(fifo_cnt)
    );

    always #18 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] f_up(input logic [5:0] a, input logic [7:0] d);
        int r3, g3, b2, r, g, b;
        r3 = int'(d[7:5]); g3 = int'(d[4:2]); b2 = int'(d[1:0]);
        r = r3 * 2 + r3 / 4;
        g = g3 * 2 + g3 / 4;
        b = b2 * 4 + ((b2 != 0) ? 2 : 0) + b2 / 2;
        return {8'(128 + int'(a)), 4'(r), 4'(g), 4'(b)};
    endfunction

    function automatic logic [19:0] f_init(input int i);
        int lvl;
        lvl = (i >= 8) ? 15 : 10;
        return {8'(i), 4'((i & 2) ? lvl : 0), 4'((i & 4) ? lvl : 0), 4'((i & 1) ? lvl : 0)};
    endfunction

    // Scoreboard state
    logic [19:0] expq[$];
    logic [19:0] wlog[$];
    int          wcyc[$];
    int          model_cnt = 0, init_left = 0, cyc = 0, atm_ack_cyc = 0, up_ack_cyc = 0;
    logic        s_init = 0;
    logic [3:0]  s_aa = 0;
    logic [11:0] s_ad = 0;
    logic [5:0]  s_ua = 0;
    logic [7:0]  s_ud = 0;

    always @(posedge clk) begin
        s_init = init_start; s_aa = atm_addr; s_ad = atm_data; s_ua = up_addr; s_ud = up_data;
    end

    always @(negedge clk) begin
        logic [19:0] e;
        logic        is_init;
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs", {pal_we, atm_ack, up_ack, busy, fifo_cnt, pal_addr, pal_wdata}, 0);
            expq.delete(); model_cnt = 0; init_left = 0;
        end else begin
            if (s_init) begin
                expq.delete(); model_cnt = 0; init_left = 16;
                for (int i = 0; i < 16; i++) expq.push_back(f_init(i));
            end
            chk("ack_exclusive", {31'd0, atm_ack & up_ack}, 0);
            if (atm_ack) begin
                expq.push_back({4'd0, s_aa, s_ad}); model_cnt++; atm_ack_cyc = cyc;
            end
            if (up_ack) begin
                expq.push_back(f_up(s_ua, s_ud)); model_cnt++; up_ack_cyc = cyc;
            end
            is_init = 0;
            if (pal_we) begin
                wlog.push_back({pal_addr, pal_wdata}); wcyc.push_back(cyc);
                if (expq.size() == 0) chk("unexpected_write", {12'd0, pal_addr, pal_wdata}, 32'hFFFFFFFF);
                else begin
                    e = expq.pop_front();
                    chk("write_entry", {12'd0, pal_addr, pal_wdata}, {12'd0, e});
                end
                if (init_left > 0) is_init = 1; else model_cnt--;
            end
            chk("fifo_cnt", 32'(fifo_cnt), 32'(model_cnt));
            chk("busy", {31'd0, busy}, {31'd0, (model_cnt != 0) || (init_left > 0)});
            if (is_init) init_left--;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic atm_write(input logic [3:0] a, input logic [11:0] d);
        int n = 0;
        atm_req = 1; atm_addr = a; atm_data = d;
        do begin @(posedge clk); #1; n++; end while (!atm_ack && n < 200);
        if (!atm_ack) chk("atm_ack_timeout", 0, 1);
        atm_req = 0;
    endtask

    task automatic up_write(input logic [5:0] a, input logic [7:0] d);
        int n = 0;
        up_req = 1; up_addr = a; up_data = d;
        do begin @(posedge clk); #1; n++; end while (!up_ack && n < 200);
        if (!up_ack) chk("up_ack_timeout", 0, 1);
        up_req = 0;
    endtask

    task automatic pulse_init();
        init_start = 1; wait_cyc(1); init_start = 0;
    endtask

    task automatic wait_init_idx(input logic [7:0] idx);
        int n = 0;
        while (!(pal_we && pal_addr == idx) && n < 40) begin wait_cyc(1); n++; end
        if (!(pal_we && pal_addr == idx)) chk("init_idx_timeout", 32'(pal_addr), 32'(idx));
    endtask

    initial begin
        int n0;
        wait_cyc(3);
        rst_n = 1;
        wait_cyc(2);

        // Single ULAplus write, immediate drain
        n0 = wlog.size();
        up_write(6'h05, 8'hE3);
        wait_cyc(4);
        chk("up_single_count", 32'(wlog.size() - n0), 1);
        if (wlog.size() > n0) begin
            chk("up_single_entry", {12'd0, wlog[n0]}, {12'd0, 8'h85, 12'hF0F});
            chk("up_latency", 32'(wcyc[n0] - up_ack_cyc), 1);
        end

        // Simultaneous requests: ATM wins, ULAplus follows
        n0 = wlog.size();
        fork
            atm_write(4'd3, 12'h123);
            up_write(6'h2A, 8'h4C);
        join
        wait_cyc(4);
        chk("arb_ack_order", 32'(up_ack_cyc - atm_ack_cyc), 1);
        chk("arb_count", 32'(wlog.size() - n0), 2);
        if (wlog.size() >= n0 + 2) begin
            chk("arb_first", {12'd0, wlog[n0]}, {12'd0, 8'h03, 12'h123});
            chk("arb_second", {12'd0, wlog[n0+1]}, {12'd0, 8'hAA, 12'h460});
        end

        // Deferred drain, FIFO full backpressure
        defer_ena = 1; n0 = wlog.size();
        fork
            for (int k = 0; k < 5; k++) atm_write(4'(k), 12'hC00 | 12'(k));
            begin
                wait_cyc(12);
                chk("full_cnt", 32'(fifo_cnt), 4);
                chk("full_busy", {31'd0, busy}, 1);
                chk("full_pending", {31'd0, atm_req}, 1);
                chk("full_no_write", 32'(wlog.size() - n0), 0);
                hblank = 1;
            end
        join
        wait_cyc(6);
        chk("drain_count", 32'(wlog.size() - n0), 5);
        if (wlog.size() >= n0 + 5) begin
            for (int k = 0; k < 5; k++)
                chk("drain_order", {12'd0, wlog[n0+k]}, {12'd0, 8'(k), 12'hC00 | 12'(k)});
            chk("drain_back_to_back", 32'(wcyc[n0+3] - wcyc[n0]), 3);
        end
        hblank = 0;

        // init_start flushes a non-empty queue
        atm_write(4'hE, 12'h111);
        atm_write(4'hD, 12'h222);
        wait_cyc(2);
        chk("queued_two", 32'(fifo_cnt), 2);
        n0 = wlog.size();
        pulse_init();
        wait_cyc(20);
        chk("init_count", 32'(wlog.size() - n0), 16);
        if (wlog.size() >= n0 + 16) begin
            for (int i = 0; i < 16; i++) chk("init_addr", 32'(wlog[n0+i][19:12]), 32'(i));
            chk("init_d1", 32'(wlog[n0+1][11:0]), 32'h00A);
            chk("init_d7", 32'(wlog[n0+7][11:0]), 32'hAAA);
            chk("init_d9", 32'(wlog[n0+9][11:0]), 32'h00F);
            chk("init_d15", 32'(wlog[n0+15][11:0]), 32'hFFF);
        end
        chk("init_idle", {27'd0, busy, fifo_cnt}, 0);

        // Restart during INIT at i = 10
        n0 = wlog.size();
        pulse_init();
        wait_init_idx(8'd10);
        pulse_init();
        wait_cyc(20);
        chk("restart_count", 32'(wlog.size() - n0), 27);
        if (wlog.size() >= n0 + 27) begin
            chk("restart_at_zero", {12'd0, wlog[n0+11]}, {12'd0, 8'h00, 12'h000});
            chk("restart_last", {12'd0, wlog[n0+26]}, {12'd0, 8'h0F, 12'hFFF});
        end

        // Asynchronous reset in the middle of INIT
        defer_ena = 0;
        pulse_init();
        wait_init_idx(8'd7);
        #5 rst_n = 0;
        #1;
        chk("rst_async", {26'd0, pal_we, busy, fifo_cnt}, 0);
        n0 = wlog.size();
        wait_cyc(3);
        rst_n = 1;
        wait_cyc(20);
        chk("rst_no_writes", 32'(wlog.size() - n0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
